serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around one full_adder with a registered carry
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry_out;
    logic [WIDTH:0]   sum_shift;

    full_adder u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry_out)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
    assign sum_shift = {fa_sum, sum_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= carry_in;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_shift[WIDTH:1];
                    carry_q <= fa_carry_out;
                    cnt     <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_sr;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder at WIDTH 8 and 1
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, out_ready, carry_in;
    logic [7:0] a, b;
    logic       in_ready, out_valid, carry_out;
    logic [7:0] sum;

    logic       in_valid1, out_ready1, carry_in1;
    logic [0:0] a1, b1;
    logic       in_ready1, out_valid1, carry_out1;
    logic [0:0] sum1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .carry_in(carry_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(carry_out1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; the result must appear WIDTH edges after the accept edge.
    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int hold);
        logic [8:0] exp;
        int         edges;
        exp = {1'b0, x} + {1'b0, y} + {8'd0, c};
        @(negedge clk);
        check("w8_in_ready_idle", in_ready, 1);
        a = x; b = y; carry_in = c; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        edges = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
            if (out_valid || edges >= 40) break;
            @(posedge clk);
            edges++;
        end
        check("w8_latency", edges, 8);
        check("w8_sum", sum, exp[7:0]);
        check("w8_carry_out", carry_out, exp[8]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, exp[7:0]);
            check("bp_carry_out", carry_out, exp[8]);
            in_valid = (i == 1);
            a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("w8_back_idle_out_valid", out_valid, 0);
        check("w8_back_idle_in_ready", in_ready, 1);
    endtask

    task automatic run_op1(input logic x, input logic y, input logic c);
        logic [1:0] exp;
        int         edges;
        exp = {1'b0, x} + {1'b0, y} + {1'b0, c};
        @(negedge clk);
        check("w1_in_ready_idle", in_ready1, 1);
        a1 = x; b1 = y; carry_in1 = c; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk);
        edges = 0;
        forever begin
            @(negedge clk);
            in_valid1 = 1'b0;
            if (out_valid1 || edges >= 20) break;
            @(posedge clk);
            edges++;
        end
        check("w1_latency", edges, 1);
        check("w1_sum", sum1, exp[0]);
        check("w1_carry_out", carry_out1, exp[1]);
        @(posedge clk);
        @(negedge clk);
        check("w1_back_idle", out_valid1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0]  exp_q[$];
        logic [8:0]  e;
        logic [7:0]  ra, rb;
        logic        rc;
        logic        seen_valid;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; carry_in = 1'b0; a = '0; b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; carry_in1 = 1'b0; a1 = '0; b1 = '0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_w1_in_ready", in_ready1, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op8(8'h0F, 8'h01, 1'b0, 0);
        run_op8(8'hFF, 8'hFF, 1'b1, 0);
        run_op8(8'h00, 8'h00, 1'b0, 0);
        run_op8(8'h80, 8'h80, 1'b0, 0);
        run_op8(8'hA5, 8'h5A, 1'b1, 5);

        // Reset during the fourth SHIFT cycle abandons the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'h01; carry_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_carry_out", carry_out, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_never_presented", seen_valid, 0);
        run_op8(8'h03, 8'h05, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), (i % 3 == 0) ? 2 : 0);
        end

        // Streaming: both handshakes held high, one accept every WIDTH+2 cycles.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (c != 0) @(negedge clk);
            check("stream_in_ready", in_ready, (c % 10) == 0);
            check("stream_out_valid", out_valid, (c % 10) == 9);
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stream_sum", sum, e[7:0]);
                check("stream_carry_out", carry_out, e[8]);
            end
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a = ra; b = rb; carry_in = rc;
            if ((c % 10) == 0) exp_q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        end
        check("stream_all_results", exp_q.size(), 0);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        run_op1(1'b1, 1'b1, 1'b1);
        run_op1(1'b0, 1'b1, 1'b0);
        run_op1(1'b1, 1'b0, 1'b1);
        run_op1(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
